// File: rtl/config_query_pkg.sv
// Shared constants and the configuration struct for the tile configuration read-back slave.
package config_query_pkg;

  localparam int unsigned ADR_W      = 16;
  localparam int unsigned DAT_W      = 32;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned CT_W       = 16;
  localparam int unsigned CTLIST_MAX = 128;
  localparam int unsigned IDX_W      = $clog2(CTLIST_MAX);

  localparam logic [DAT_W-1:0] VERSION = 32'h0000_0002;

  localparam logic [ADR_W-1:0] REG_VERSION        = 16'h000;
  localparam logic [ADR_W-1:0] REG_TILEID         = 16'h004;
  localparam logic [ADR_W-1:0] REG_NUMTILES       = 16'h008;
  localparam logic [ADR_W-1:0] REG_CT_RANK        = 16'h00C;
  localparam logic [ADR_W-1:0] REG_NUMCTS         = 16'h010;
  localparam logic [ADR_W-1:0] REG_CORES_PER_TILE = 16'h014;
  localparam logic [ADR_W-1:0] REG_TOTAL_CORES    = 16'h018;
  localparam logic [ADR_W-1:0] REG_COREBASE       = 16'h01C;
  localparam logic [ADR_W-1:0] REG_GMEM_SIZE      = 16'h020;
  localparam logic [ADR_W-1:0] REG_GMEM_TILE      = 16'h024;
  localparam logic [ADR_W-1:0] REG_LMEM_SIZE      = 16'h028;
  localparam logic [ADR_W-1:0] REG_FEATURES       = 16'h02C;
  localparam logic [ADR_W-1:0] REG_NA_DMA_ENTRIES = 16'h030;
  localparam logic [ADR_W-1:0] REG_DEBUG_NUM_MODS = 16'h034;

  localparam logic [ADR_W-1:0] CTLIST_BASE = 16'h0200;
  localparam logic [ADR_W-1:0] CTLIST_SIZE = 16'h0200;

  localparam int unsigned FEAT_NA_MPSIMPLE   = 0;
  localparam int unsigned FEAT_NA_DMA        = 1;
  localparam int unsigned FEAT_NA_DMA_GENIRQ = 2;
  localparam int unsigned FEAT_PGAS          = 3;
  localparam int unsigned FEAT_DM            = 4;
  localparam int unsigned FEAT_USE_DEBUG     = 5;
  localparam int unsigned FEAT_CORE_FPU      = 6;
  localparam int unsigned FEAT_NOC_VCHANNELS = 7;

  typedef struct packed {
    logic [31:0]                      numtiles;
    logic [31:0]                      numcts;
    logic [CTLIST_MAX-1:0][CT_W-1:0]  ctlist;
    logic [31:0]                      cores_per_tile;
    logic [31:0]                      total_num_cores;
    logic [31:0]                      gmem_size;
    logic [31:0]                      gmem_tile;
    logic [31:0]                      lmem_size;
    logic                             na_enable_mpsimple;
    logic                             na_enable_dma;
    logic                             na_dma_genirq;
    logic                             enable_pgas;
    logic                             enable_dm;
    logic                             use_debug;
    logic                             core_enable_fpu;
    logic                             noc_enable_vchannels;
    logic [31:0]                      na_dma_entries;
    logic [31:0]                      debug_num_mods;
  } config_t;

  localparam config_t DEFAULT_CONFIG = '0;

  // Compute-tile count as seen by the scan and the CTLIST window.
  function automatic int unsigned clamp_numcts(input int unsigned n);
    return (n > CTLIST_MAX) ? CTLIST_MAX : n;
  endfunction

endpackage

// File: rtl/config_query_slave_if.sv
// Wishbone classic read/write bus between a master and the configuration slave.
interface config_query_slave_if;
  import config_query_pkg::*;

  logic [ADR_W-1:0] wb_adr_i;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_we_i;
  logic [SEL_W-1:0] wb_sel_i;
  logic [DAT_W-1:0] wb_dat_i;
  logic [DAT_W-1:0] wb_dat_o;
  logic             wb_ack_o;
  logic             wb_err_o;

  modport master (
    output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/config_query_slave_ct_rank_search.sv
// Post-reset linear scan of CTLIST to find this tile's compute-tile rank.
module ct_rank_search
  import config_query_pkg::*;
#(
  parameter logic [CTLIST_MAX-1:0][CT_W-1:0] CTLIST = '0,
  parameter int unsigned                     NUMCTS = 0,
  parameter int unsigned                     TILEID = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        done_o,
  output logic [31:0] rank_o
);

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam int unsigned      NUMCTS_C = clamp_numcts(NUMCTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((NUMCTS_C == 0) ? 0 : NUMCTS_C - 1);

  logic [0:0]       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [31:0]      r_rank, w_rank_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SCAN;
      r_idx   <= '0;
      r_rank  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rank  <= w_rank_nxt;
    end
  end

  // One CTLIST entry per cycle; an empty list finishes immediately with no rank.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rank_nxt  = r_rank;
    if (r_state == ST_SCAN) begin
      if (NUMCTS_C == 0) begin
        w_state_nxt = ST_DONE;
      end else if (CTLIST[r_idx] == CT_W'(TILEID)) begin
        w_rank_nxt  = 32'(r_idx);
        w_state_nxt = ST_DONE;
      end else if (r_idx == LAST_IDX) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end
  end

  assign done_o = (r_state == ST_DONE);
  assign rank_o = r_rank;

endmodule

// File: rtl/config_query_slave.sv
// Read-only Wishbone slave exposing the tile's static configuration and its compute-tile rank.
module config_query_slave
  import config_query_pkg::*;
#(
  parameter config_t     CONFIG   = DEFAULT_CONFIG,
  parameter int unsigned TILEID   = 0,
  parameter int unsigned COREBASE = 0
) (
  input logic                 clk,
  input logic                 rst,
  config_query_slave_if.slave bus
);

  localparam int unsigned NUMCTS_C = clamp_numcts(32'(CONFIG.numcts));

  logic             w_rank_done;
  logic [31:0]      w_rank;
  logic [ADR_W-1:0] w_word_adr;
  logic [IDX_W-1:0] w_ct_idx;
  logic             w_hit;
  logic             w_is_rank;
  logic [DAT_W-1:0] w_rdata;
  logic [DAT_W-1:0] w_features;
  logic             w_req;
  logic             w_unused;

  logic             r_ack;
  logic             r_err;
  logic [DAT_W-1:0] r_dat;

  ct_rank_search #(
    .CTLIST (CONFIG.ctlist),
    .NUMCTS (32'(CONFIG.numcts)),
    .TILEID (TILEID)
  ) u_rank (
    .clk    (clk),
    .rst    (rst),
    .done_o (w_rank_done),
    .rank_o (w_rank)
  );

  assign w_word_adr = {bus.wb_adr_i[ADR_W-1:2], 2'b00};
  assign w_ct_idx   = bus.wb_adr_i[IDX_W+1:2];
  assign w_unused   = ^{bus.wb_sel_i, bus.wb_dat_i, bus.wb_adr_i[1:0]};

  always_comb begin
    w_features = '0;
    w_features[FEAT_NA_MPSIMPLE]   = CONFIG.na_enable_mpsimple;
    w_features[FEAT_NA_DMA]        = CONFIG.na_enable_dma;
    w_features[FEAT_NA_DMA_GENIRQ] = CONFIG.na_dma_genirq;
    w_features[FEAT_PGAS]          = CONFIG.enable_pgas;
    w_features[FEAT_DM]            = CONFIG.enable_dm;
    w_features[FEAT_USE_DEBUG]     = CONFIG.use_debug;
    w_features[FEAT_CORE_FPU]      = CONFIG.core_enable_fpu;
    w_features[FEAT_NOC_VCHANNELS] = CONFIG.noc_enable_vchannels;
  end

  // Address decode; CTLIST entries past the compute-tile count read as zero.
  always_comb begin
    w_hit     = 1'b1;
    w_is_rank = 1'b0;
    w_rdata   = '0;
    if ((bus.wb_adr_i & ~(CTLIST_SIZE - 16'd1)) == CTLIST_BASE) begin
      if (32'(w_ct_idx) < NUMCTS_C) w_rdata = DAT_W'(CONFIG.ctlist[w_ct_idx]);
    end else begin
      case (w_word_adr)
        REG_VERSION:        w_rdata = VERSION;
        REG_TILEID:         w_rdata = DAT_W'(TILEID);
        REG_NUMTILES:       w_rdata = CONFIG.numtiles;
        REG_CT_RANK: begin
          w_rdata   = w_rank;
          w_is_rank = 1'b1;
        end
        REG_NUMCTS:         w_rdata = CONFIG.numcts;
        REG_CORES_PER_TILE: w_rdata = CONFIG.cores_per_tile;
        REG_TOTAL_CORES:    w_rdata = CONFIG.total_num_cores;
        REG_COREBASE:       w_rdata = DAT_W'(COREBASE);
        REG_GMEM_SIZE:      w_rdata = CONFIG.gmem_size;
        REG_GMEM_TILE:      w_rdata = CONFIG.gmem_tile;
        REG_LMEM_SIZE:      w_rdata = CONFIG.lmem_size;
        REG_FEATURES:       w_rdata = w_features;
        REG_NA_DMA_ENTRIES: w_rdata = CONFIG.na_dma_entries;
        REG_DEBUG_NUM_MODS: w_rdata = CONFIG.debug_num_mods;
        default:            w_hit   = 1'b0;
      endcase
    end
  end

  // Suppressing requests while a response is out makes every response a one-cycle pulse.
  assign w_req = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack & ~r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      if (w_req) begin
        if (bus.wb_we_i || !w_hit) begin
          r_err <= 1'b1;
        end else if (!w_is_rank || w_rank_done) begin
          r_ack <= 1'b1;
          r_dat <= w_rdata;
        end
      end
    end
  end

  assign bus.wb_ack_o = r_ack;
  assign bus.wb_err_o = r_err;
  assign bus.wb_dat_o = r_dat;

endmodule

// File: tb/tb_config_query_slave.sv
// Directed bench: four slaves with different configurations share one request bus.
module tb_config_query_slave;
  import config_query_pkg::*;

  typedef struct {
    int unsigned  dut;
    logic [15:0]  adr;
    logic         we;
    logic         err;
    logic [31:0]  dat;
  } vec_t;

  function automatic config_t mk_cfg(input int unsigned numcts, input int unsigned cpt,
                                     input int unsigned total, input logic [7:0] feat);
    config_t c;
    c = '0;
    c.numtiles             = 32'd4;
    c.numcts               = numcts;
    c.ctlist[0]            = 16'd0;
    c.ctlist[1]            = 16'd2;
    c.ctlist[2]            = 16'd5;
    c.ctlist[3]            = 16'd7;
    c.cores_per_tile       = cpt;
    c.total_num_cores      = total;
    c.gmem_size            = 32'h0100_0000;
    c.gmem_tile            = 32'd3;
    c.lmem_size            = 32'h0000_8000;
    c.na_enable_mpsimple   = feat[0];
    c.na_enable_dma        = feat[1];
    c.na_dma_genirq        = feat[2];
    c.enable_pgas          = feat[3];
    c.enable_dm            = feat[4];
    c.use_debug            = feat[5];
    c.core_enable_fpu      = feat[6];
    c.noc_enable_vchannels = feat[7];
    c.na_dma_entries       = 32'd4;
    c.debug_num_mods       = 32'd6;
    return c;
  endfunction

  localparam config_t CFG_A = mk_cfg(3, 1, 3, 8'h61);
  localparam config_t CFG_B = mk_cfg(3, 1, 3, 8'h00);
  localparam config_t CFG_C = mk_cfg(0, 1, 0, 8'h00);
  localparam config_t CFG_D = mk_cfg(4, 2, 8, 8'h9E);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int          first_ack[4];
  logic [31:0] first_dat[4];
  vec_t        vecs[$];

  logic        ack_v[4];
  logic        err_v[4];
  logic [31:0] dat_v[4];

  config_query_slave_if bus_a ();
  config_query_slave_if bus_b ();
  config_query_slave_if bus_c ();
  config_query_slave_if bus_d ();

  assign bus_a.wb_adr_i = adr; assign bus_a.wb_cyc_i = cyc; assign bus_a.wb_stb_i = stb;
  assign bus_a.wb_we_i  = we;  assign bus_a.wb_sel_i = 4'hF; assign bus_a.wb_dat_i = 32'hDEAD_BEEF;
  assign bus_b.wb_adr_i = adr; assign bus_b.wb_cyc_i = cyc; assign bus_b.wb_stb_i = stb;
  assign bus_b.wb_we_i  = we;  assign bus_b.wb_sel_i = 4'hF; assign bus_b.wb_dat_i = 32'hDEAD_BEEF;
  assign bus_c.wb_adr_i = adr; assign bus_c.wb_cyc_i = cyc; assign bus_c.wb_stb_i = stb;
  assign bus_c.wb_we_i  = we;  assign bus_c.wb_sel_i = 4'hF; assign bus_c.wb_dat_i = 32'hDEAD_BEEF;
  assign bus_d.wb_adr_i = adr; assign bus_d.wb_cyc_i = cyc; assign bus_d.wb_stb_i = stb;
  assign bus_d.wb_we_i  = we;  assign bus_d.wb_sel_i = 4'hF; assign bus_d.wb_dat_i = 32'hDEAD_BEEF;

  assign ack_v[0] = bus_a.wb_ack_o; assign err_v[0] = bus_a.wb_err_o; assign dat_v[0] = bus_a.wb_dat_o;
  assign ack_v[1] = bus_b.wb_ack_o; assign err_v[1] = bus_b.wb_err_o; assign dat_v[1] = bus_b.wb_dat_o;
  assign ack_v[2] = bus_c.wb_ack_o; assign err_v[2] = bus_c.wb_err_o; assign dat_v[2] = bus_c.wb_dat_o;
  assign ack_v[3] = bus_d.wb_ack_o; assign err_v[3] = bus_d.wb_err_o; assign dat_v[3] = bus_d.wb_dat_o;

  config_query_slave #(.CONFIG(CFG_A), .TILEID(5), .COREBASE(0)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  config_query_slave #(.CONFIG(CFG_B), .TILEID(1), .COREBASE(3)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  config_query_slave #(.CONFIG(CFG_C), .TILEID(0), .COREBASE(0)) u_c (.clk(clk), .rst(rst), .bus(bus_c));
  config_query_slave #(.CONFIG(CFG_D), .TILEID(7), .COREBASE(6)) u_d (.clk(clk), .rst(rst), .bus(bus_d));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input int unsigned d, input logic [15:0] a, input logic w,
                     input logic e, input logic [31:0] v);
    vec_t t;
    t.dut = d; t.adr = a; t.we = w; t.err = e; t.dat = v;
    vecs.push_back(t);
  endtask

  // Reset for one edge, then release and hold a read; record each slave's first ack edge.
  task automatic reset_read(input logic [15:0] a, input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++)
      check($sformatf("%s rst_out dut%0d", tag, d), 64'({ack_v[d], err_v[d], dat_v[d]}), 64'd0);
    rst = 1'b0; adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int d = 0; d < 4; d++) begin first_ack[d] = 0; first_dat[d] = '0; end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++)
        if (ack_v[d] && first_ack[d] == 0) begin first_ack[d] = c; first_dat[d] = dat_v[d]; end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;

    // Rank read right after reset: ack waits for the scan.
    reset_read(REG_CT_RANK, "rank");
    check("rank_lat_a",  64'(first_ack[0]), 64'd4);
    check("rank_dat_a",  64'(first_dat[0]), 64'd2);
    check("rank_lat_b",  64'(first_ack[1]), 64'd4);
    check("rank_dat_b",  64'(first_dat[1]), 64'hFFFF_FFFF);
    check("rank_lat_c",  64'(first_ack[2]), 64'd2);
    check("rank_dat_c",  64'(first_dat[2]), 64'hFFFF_FFFF);
    check("rank_lat_d",  64'(first_ack[3]), 64'd5);
    check("rank_dat_d",  64'(first_dat[3]), 64'd3);

    // Other registers answer normally while the scan is running.
    reset_read(REG_VERSION, "scanver");
    for (int d = 0; d < 4; d++) begin
      check($sformatf("scanver_lat dut%0d", d), 64'(first_ack[d]), 64'd1);
      check($sformatf("scanver_dat dut%0d", d), 64'(first_dat[d]), 64'd2);
    end

    // Rank read abandoned mid-scan produces no response.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; adr = REG_CT_RANK; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) acks += int'(ack_v[d]) + int'(err_v[d]);
    end
    check("dropped_req_resp", 64'(acks), 64'd0);

    // Directed register-map vectors (all scans done).
    add(0, 16'h000, 0, 0, 32'h0000_0002); add(0, 16'h004, 0, 0, 32'd5);
    add(0, 16'h008, 0, 0, 32'd4);         add(0, 16'h00C, 0, 0, 32'd2);
    add(0, 16'h010, 0, 0, 32'd3);         add(0, 16'h014, 0, 0, 32'd1);
    add(0, 16'h018, 0, 0, 32'd3);         add(0, 16'h01C, 0, 0, 32'd0);
    add(0, 16'h020, 0, 0, 32'h0100_0000); add(0, 16'h024, 0, 0, 32'd3);
    add(0, 16'h028, 0, 0, 32'h0000_8000); add(0, 16'h02C, 0, 0, 32'h0000_0061);
    add(0, 16'h030, 0, 0, 32'd4);         add(0, 16'h034, 0, 0, 32'd6);
    add(0, 16'h200, 0, 0, 32'd0);         add(0, 16'h206, 0, 0, 32'd2);
    add(0, 16'h208, 0, 0, 32'd5);         add(0, 16'h20C, 0, 0, 32'd0);
    add(0, 16'h3FC, 0, 0, 32'd0);         add(0, 16'h038, 0, 1, 32'd0);
    add(0, 16'h004, 1, 1, 32'd0);         add(0, 16'h004, 0, 0, 32'd5);
    add(0, 16'h1FC, 0, 1, 32'd0);         add(0, 16'h400, 0, 1, 32'd0);
    add(1, 16'h00C, 0, 0, 32'hFFFF_FFFF); add(1, 16'h004, 0, 0, 32'd1);
    add(1, 16'h01C, 0, 0, 32'd3);
    add(2, 16'h00C, 0, 0, 32'hFFFF_FFFF); add(2, 16'h010, 0, 0, 32'd0);
    add(2, 16'h200, 0, 0, 32'd0);
    add(3, 16'h018, 0, 0, 32'd8);         add(3, 16'h01C, 0, 0, 32'd6);
    add(3, 16'h000, 0, 0, 32'h0000_0002); add(3, 16'h00C, 0, 0, 32'd3);
    add(3, 16'h20C, 0, 0, 32'd7);         add(3, 16'h02C, 0, 0, 32'h0000_009E);
    add(3, 16'h014, 0, 0, 32'd2);         add(3, 16'h010, 0, 0, 32'd4);

    foreach (vecs[i]) begin
      int unsigned d;
      d = vecs[i].dut;
      adr = vecs[i].adr; we = vecs[i].we; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check($sformatf("vec%0d dut%0d adr=%h we=%0d", i, d, vecs[i].adr, vecs[i].we),
            64'({ack_v[d], err_v[d], dat_v[d]}),
            64'({~vecs[i].err, vecs[i].err, vecs[i].dat}));
      @(posedge clk); #1;
      check($sformatf("vec%0d pulse_end dut%0d", i, d), 64'({ack_v[d], err_v[d]}), 64'd0);
    end

    // Strobe held: acks alternate, never back to back.
    adr = REG_VERSION; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("b2b cycle%0d", c), 64'({ack_v[0], err_v[0]}), 64'({c[0], 1'b0}));
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Reset while a rank read is pending: nothing comes back, retry sees a fresh scan.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; adr = REG_CT_RANK; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_pending_a", 64'(ack_v[0]), 64'd0);
    check("midrst_c_acked",   64'({ack_v[2], dat_v[2]}), 64'({1'b1, 32'hFFFF_FFFF}));
    reset_read(REG_CT_RANK, "retry");
    check("retry_lat_a", 64'(first_ack[0]), 64'd4);
    check("retry_dat_a", 64'(first_dat[0]), 64'd2);
    check("retry_lat_d", 64'(first_ack[3]), 64'd5);
    check("retry_dat_d", 64'(first_dat[3]), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/config_query_slave.md
Name: config_query_slave

Overview:
- Read-only Wishbone slave that exposes the tile's static system configuration (the config_t struct) to software at run time.
- It is the read-back end of the configuration flow: derive_config produces the struct at elaboration, and this block lets the core read it over the bus.
- It sits in each compute tile on the local bus, next to the network adapter.
- After reset it runs a short scan to find the tile's compute-tile rank in CTLIST.

Parameters:
- CONFIG, (none; required), optimsoc_config::config_t for the system.
- TILEID, 0, NoC tile id of this tile.
- COREBASE, 0, global index of this tile's first core.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wb_adr_i  in  16  byte address; bits [1:0] ignored
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte selects; ignored
- wb_dat_i  in  32  write data; ignored
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  read acknowledge
- wb_err_o  out  1  error response

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While rst is high: wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - Scan state is set to SCAN with idx=0 and rank=32'hFFFF_FFFF.
- Register map (32-bit word, zero-extended):
  - 0x000 VERSION = 32'h0000_0002
  - 0x004 TILEID
  - 0x008 NUMTILES
  - 0x00C CT_RANK
  - 0x010 NUMCTS
  - 0x014 CORES_PER_TILE
  - 0x018 TOTAL_NUM_CORES
  - 0x01C COREBASE
  - 0x020 GMEM_SIZE
  - 0x024 GMEM_TILE
  - 0x028 LMEM_SIZE
  - 0x02C FEATURES: b0 NA_ENABLE_MPSIMPLE, b1 NA_ENABLE_DMA, b2 NA_DMA_GENIRQ, b3 ENABLE_PGAS, b4 ENABLE_DM, b5 USE_DEBUG, b6 CORE_ENABLE_FPU, b7 NOC_ENABLE_VCHANNELS; other bits 0
  - 0x030 NA_DMA_ENTRIES
  - 0x034 DEBUG_NUM_MODS
  - 0x200–0x3FC CTLIST[(adr-0x200)>>2]: 16-bit entry zero-extended; returns 0 when the index is >= NUMCTS.
- Handshake:
  - A request is cyc&stb with wb_ack_o=0 and wb_err_o=0.
  - Read to a mapped address: wb_ack_o=1 on the next cycle for exactly one cycle, with wb_dat_o valid in that cycle.
  - Write to any address, or read to an unmapped address: wb_err_o=1 for one cycle, 1-cycle latency, wb_dat_o=0.
  - Responses are single-cycle pulses, so the minimum spacing of accepted requests is 2 cycles.
  - If cyc or stb drops before a response is issued, the request is dropped and no response is generated.
- CT_RANK reads during SCAN:
  - The response is withheld while the request stays asserted.
  - wb_ack_o is issued the cycle after the scan reaches DONE.
  - All other registers respond normally during SCAN.
- Rank-scan FSM, states SCAN and DONE:
  - Each SCAN cycle compares CTLIST[idx] with TILEID.
  - On a match: rank=idx, go to DONE.
  - Else if idx==NUMCTS-1: go to DONE with rank left at all-ones.
  - Else idx++.
  - NUMCTS==0: go to DONE on the first cycle after reset with rank all-ones.
  - Latency: a match at index k is DONE k+1 cycles after rst deasserts.
  - idx is clog2(128)=7 bits; NUMCTS is clamped to 128.
  - DONE is held until the next reset.
- Reset mid-transaction: a pending response is discarded, the scan restarts, and the master must retry.

Decomposition:
- Package config_query_pkg holds:
  - the register-offset localparams;
  - the FEATURES bit indices;
  - the VERSION constant;
  - the CTLIST window base 0x200 and its size.
- Sub-module ct_rank_search holds the scan FSM.
  - Parameters: CTLIST, NUMCTS, TILEID.
  - Ports: clk, rst, done_o, rank_o[31:0].
- The top level holds the address decode, response registers and handshake.

Test Plan:
1. CTLIST={0,2,5}, NUMCTS=3, TILEID=5; read 0x00C immediately after reset → ack delayed; data=2; ack arrives 4 cycles after the request (3-cycle scan plus 1).
2. TILEID=1, not in CTLIST → after DONE, 0x00C returns 32'hFFFF_FFFF; NUMCTS=0 → DONE after 1 cycle with the same value.
3. NUMCTS=4, CORES_PER_TILE=2, COREBASE=6 → 0x018 returns 8, 0x01C returns 6, 0x000 returns 32'h0000_0002, each with a 1-cycle ack.
4. FPU=1, MPSIMPLE=1, DMA=0, USE_DEBUG=1 → 0x02C returns 32'h0000_0061; 0x204 returns CTLIST[1]=2; 0x20C (index 3 >= NUMCTS) returns 0.
5. Write to 0x004, and read of 0x038 → wb_err_o pulses 1 cycle, wb_ack_o stays 0; register contents are unchanged on re-read.
6. stb held continuously for back-to-back reads → ack every other cycle, never two consecutive cycles. Assert rst during a pending CT_RANK read → no ack; scan restarts; after a retry, the correct rank is returned.
